// File: rtl/counter_sched_pkg.sv
// counter_sched shared types and defaults.
// Optional feature macro: COUNTER_SCHED_TIMEOUT_EN.
package counter_sched_pkg;

  localparam int NREQ         = 2;
  localparam int DEF_WIDTH    = 7;
  localparam int DEF_PRESCALE = 2;
  localparam int DEF_TIMEOUT  = 1024;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DONE
  } state_e;

  function automatic logic [NREQ-1:0] rr_pick(
    input logic [NREQ-1:0] req,
    input logic            ptr
  );
    logic [NREQ-1:0] g;
    g = '0;
    if (ptr) begin
      if (req[1])      g = 2'b10;
      else if (req[0]) g = 2'b01;
    end else begin
      if (req[0])      g = 2'b01;
      else if (req[1]) g = 2'b10;
    end
    return g;
  endfunction

endpackage

// File: rtl/counter_sched_rr_arb2.sv
// Two-way round-robin arbiter for counter_sched.
// ptr names the requester that currently has priority.
module rr_arb2
  import counter_sched_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic            ptr,
  output logic [NREQ-1:0] grant
);

  always_comb begin
    grant = rr_pick(req, ptr);
  end

endmodule

// File: rtl/counter_sched.sv
// Shared-counter scheduler: arbitrates two requesters onto one counter.
// Optional macro COUNTER_SCHED_TIMEOUT_EN adds a RUN-cycle timeout.
module counter_sched
  import counter_sched_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int PRESCALE = DEF_PRESCALE,
  parameter int TIMEOUT  = DEF_TIMEOUT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         req,
  input  logic [2*WIDTH-1:0] req_n,
  output logic [1:0]         gnt,
  output logic [1:0]         rsp_valid,
  output logic [31:0]        rsp_data,
  output logic               rsp_err,
  output logic               busy,
  output logic [WIDTH-1:0]   cnt_N,
  output logic               cnt_en,
  output logic               cnt_clr,
  input  logic [31:0]        cnt_out,
  input  logic               cnt_done
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  state_e          state;
  state_e          state_nx;
  logic            ptr;
  logic [1:0]      arb_gnt;
  logic [PW-1:0]   pscnt;
  logic [WIDTH-1:0] sel_n;
  logic            own_req;
  logic            ps_hit;
  logic            to_hit;
  logic            finish;

  rr_arb2 u_arb (
    .req   (req),
    .ptr   (ptr),
    .grant (arb_gnt)
  );

  assign sel_n   = arb_gnt[1] ? req_n[WIDTH +: WIDTH]
                              : req_n[0 +: WIDTH];
  assign own_req = |(req & gnt);
  assign ps_hit  = (pscnt == PW'(PRESCALE - 1));
  assign finish  = cnt_done | to_hit;
  assign busy    = (state != S_IDLE);

`ifdef COUNTER_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] tcnt;
  logic          err_q;

  assign to_hit  = (state == S_RUN) &&
                   (tcnt == TW'(TIMEOUT - 1));
  assign rsp_err = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tcnt  <= '0;
      err_q <= 1'b0;
    end else begin
      if (state == S_LOAD) begin
        tcnt  <= '0;
        err_q <= 1'b0;
      end else if (state == S_RUN) begin
        tcnt <= tcnt + 1'b1;
        if (finish) err_q <= ~cnt_done;
      end
    end
  end
`else
  logic unused_timeout;

  assign unused_timeout = (TIMEOUT == 0);
  assign to_hit         = 1'b0;
  assign rsp_err        = 1'b0;
`endif

  always_comb begin
    state_nx  = state;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;
    rsp_valid = '0;
    unique case (state)
      S_IDLE: begin
        if (|req) state_nx = S_LOAD;
      end
      S_LOAD: begin
        cnt_clr = 1'b1;
        if (!own_req)         state_nx = S_IDLE;
        else if (cnt_N == '0) state_nx = S_DONE;
        else                  state_nx = S_RUN;
      end
      S_RUN: begin
        // abort clears the counter so the next owner starts clean
        if (!own_req) begin
          cnt_clr  = 1'b1;
          state_nx = S_IDLE;
        end else if (finish) begin
          state_nx = S_DONE;
        end else begin
          cnt_en = ps_hit;
        end
      end
      S_DONE: begin
        rsp_valid = gnt;
        state_nx  = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      ptr      <= 1'b0;
      gnt      <= '0;
      cnt_N    <= '0;
      pscnt    <= '0;
      rsp_data <= '0;
    end else begin
      state <= state_nx;
      unique case (state)
        S_IDLE: begin
          if (|req) begin
            gnt   <= arb_gnt;
            cnt_N <= sel_n;
            ptr   <= arb_gnt[0];
          end
        end
        S_LOAD: begin
          pscnt    <= '0;
          rsp_data <= '0;
          if (!own_req) gnt <= '0;
        end
        S_RUN: begin
          pscnt <= ps_hit ? '0 : pscnt + 1'b1;
          if (!own_req)    gnt      <= '0;
          else if (finish) rsp_data <= cnt_out;
        end
        S_DONE: begin
          gnt <= '0;
        end
        default: gnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_counter_sched.sv
// Directed bench for counter_sched with a behavioural shared counter.
// Optional macro COUNTER_SCHED_TIMEOUT_EN adds a timeout scenario.
module tb_counter_sched;

  localparam int W  = 7;
  localparam int PS = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    req = '0;
  logic [2*W-1:0] req_n = '0;
  logic [1:0]    gnt;
  logic [1:0]    rsp_valid;
  logic [31:0]   rsp_data;
  logic          rsp_err;
  logic          busy;
  logic [W-1:0]  cnt_N;
  logic          cnt_en;
  logic          cnt_clr;
  logic [31:0]   cnt_out;
  logic          cnt_done;

  logic [31:0]   model_cnt = '0;
  int            en_pulses = 0;
  int            cyc = 0;
  int            last_en = -1;
  int            gap_err = 0;

  int            n_assert = 0;
  int            n_fail = 0;
  logic [1:0]    r_valid;
  logic [31:0]   r_data;
  logic          r_err;
  int            r_cyc;
  int            e0;

  always #5 clk = ~clk;

  counter_sched #(.WIDTH(W), .PRESCALE(PS)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_n     (req_n),
    .gnt       (gnt),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .cnt_N     (cnt_N),
    .cnt_en    (cnt_en),
    .cnt_clr   (cnt_clr),
    .cnt_out   (cnt_out),
    .cnt_done  (cnt_done)
  );

  assign cnt_out  = model_cnt;
  assign cnt_done = (model_cnt == {25'd0, cnt_N});

  always @(posedge clk or posedge rst) begin
    if (rst)          model_cnt <= '0;
    else if (cnt_clr) model_cnt <= '0;
    else if (cnt_en)  model_cnt <= model_cnt + 1;
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cnt_en) en_pulses <= en_pulses + 1;
    if (cnt_clr || rst) begin
      last_en <= -1;
    end else if (cnt_en) begin
      if (last_en >= 0 && cyc - last_en != PS)
        gap_err <= gap_err + 1;
      last_en <= cyc;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic wait_rsp(input int max);
    bit seen;
    seen    = 1'b0;
    r_cyc   = -1;
    r_valid = '0;
    r_data  = '0;
    r_err   = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (!seen) begin
        step();
        if (rsp_valid != 2'b00) begin
          seen    = 1'b1;
          r_cyc   = i;
          r_valid = rsp_valid;
          r_data  = rsp_data;
          r_err   = rsp_err;
        end
      end
    end
  endtask

`ifdef COUNTER_SCHED_TIMEOUT_EN
  logic [1:0]    t_req = '0;
  logic [2*W-1:0] t_n = '0;
  logic [1:0]    t_gnt;
  logic [1:0]    t_rv;
  logic [31:0]   t_rd;
  logic          t_re;
  logic          t_busy;
  logic [W-1:0]  t_cn;
  logic          t_en;
  logic          t_clr;

  counter_sched #(.WIDTH(W), .PRESCALE(PS),
                  .TIMEOUT(16)) dut_to (
    .clk       (clk),
    .rst       (rst),
    .req       (t_req),
    .req_n     (t_n),
    .gnt       (t_gnt),
    .rsp_valid (t_rv),
    .rsp_data  (t_rd),
    .rsp_err   (t_re),
    .busy      (t_busy),
    .cnt_N     (t_cn),
    .cnt_en    (t_en),
    .cnt_clr   (t_clr),
    .cnt_out   (32'h55),
    .cnt_done  (1'b0)
  );
`endif

  initial begin
    // reset state
    step();
    step();
    chk("rst_gnt", {30'd0, gnt}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_clr", {31'd0, cnt_clr}, 0);
    chk("rst_data", rsp_data, 0);
    rst = 1'b0;
    step();

    // single requester 0, N=14
    req   = 2'b01;
    req_n = {7'd0, 7'd14};
    e0    = en_pulses;
    step();
    chk("t1_gnt", {30'd0, gnt}, 32'h1);
    chk("t1_clr", {31'd0, cnt_clr}, 1);
    chk("t1_busy", {31'd0, busy}, 1);
    chk("t1_cntN", {25'd0, cnt_N}, 14);
    wait_rsp(100);
    chk("t1_lat", r_cyc, 29);
    chk("t1_valid", {30'd0, r_valid}, 32'h1);
    chk("t1_data", r_data, 14);
    chk("t1_err", {31'd0, r_err}, 0);
    chk("t1_pulses", en_pulses - e0, 14);
    chk("t1_gap", gap_err, 0);
    req = 2'b00;
    step();
    chk("t1_idle_busy", {31'd0, busy}, 0);
    chk("t1_idle_gnt", {30'd0, gnt}, 0);

    // requester 1 with N=0 skips RUN
    req   = 2'b10;
    req_n = {7'd0, 7'd9};
    e0    = en_pulses;
    step();
    chk("t3_gnt", {30'd0, gnt}, 32'h2);
    wait_rsp(10);
    chk("t3_lat", r_cyc, 0);
    chk("t3_valid", {30'd0, r_valid}, 32'h2);
    chk("t3_data", r_data, 0);
    chk("t3_pulses", en_pulses - e0, 0);
    req = 2'b00;
    step();

    // both held: grants alternate 0,1,0
    req   = 2'b11;
    req_n = {7'd5, 7'd3};
    wait_rsp(100);
    chk("t2_v0", {30'd0, r_valid}, 32'h1);
    chk("t2_d0", r_data, 3);
    wait_rsp(100);
    chk("t2_v1", {30'd0, r_valid}, 32'h2);
    chk("t2_d1", r_data, 5);
    wait_rsp(100);
    chk("t2_v2", {30'd0, r_valid}, 32'h1);
    chk("t2_d2", r_data, 3);
    req = 2'b00;
    step();
    chk("t2_gap", gap_err, 0);

    // abort after 4 pulses of an N=10 run
    req   = 2'b01;
    req_n = {7'd0, 7'd10};
    step();
    e0 = en_pulses;
    for (int i = 0; i < 40; i++)
      if (en_pulses - e0 < 4) step();
    chk("t4_pulses", en_pulses - e0, 4);
    req = 2'b00;
    #1;
    chk("t4_clr", {31'd0, cnt_clr}, 1);
    chk("t4_novalid", {30'd0, rsp_valid}, 0);
    step();
    chk("t4_busy", {31'd0, busy}, 0);
    chk("t4_gnt", {30'd0, gnt}, 0);
    chk("t4_cnt", model_cnt, 0);
    step();
    chk("t4_norsp", {30'd0, rsp_valid}, 0);

    // reset mid-run, then pointer back at 0
    req   = 2'b01;
    req_n = {7'd10, 7'd10};
    step();
    for (int i = 0; i < 5; i++) step();
    chk("t5_pre_busy", {31'd0, busy}, 1);
    rst = 1'b1;
    #1;
    chk("t5_gnt", {30'd0, gnt}, 0);
    chk("t5_busy", {31'd0, busy}, 0);
    chk("t5_en", {31'd0, cnt_en}, 0);
    chk("t5_clr", {31'd0, cnt_clr}, 0);
    chk("t5_cntN", {25'd0, cnt_N}, 0);
    chk("t5_data", rsp_data, 0);
    chk("t5_valid", {30'd0, rsp_valid}, 0);
    req = 2'b11;
    #1;
    rst = 1'b0;
    step();
    chk("t5_regnt", {30'd0, gnt}, 32'h1);
    req = 2'b00;
    step();
    step();

`ifdef COUNTER_SCHED_TIMEOUT_EN
    // timeout with cnt_done stuck low
    t_req = 2'b01;
    t_n   = {7'd0, 7'd5};
    step();
    step();
    r_cyc = -1;
    r_err = 1'b0;
    r_data = '0;
    for (int i = 0; i < 40; i++) begin
      if (r_cyc < 0 && t_rv != 2'b00) begin
        r_cyc  = i;
        r_err  = t_re;
        r_data = t_rd;
      end
      if (r_cyc < 0) step();
    end
    chk("to_lat", r_cyc, 16);
    chk("to_err", {31'd0, r_err}, 1);
    chk("to_data", r_data, 32'h55);
    t_req = 2'b00;
    step();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/counter_sched.md
COUNTER_SCHED -- requirements
Module: counter_sched

Interface
REQ-001 SHALL have parameter WIDTH, default 7, bit width of the requested count N.
REQ-002 SHALL have parameter PRESCALE, default 2, clk cycles between cnt_en pulses (legal range 1..255).
REQ-003 SHALL have parameter TIMEOUT, default 1024, RUN-cycle limit (used only with the timeout feature).
REQ-004 SHALL have port clk  input  1  the single clock; all logic is rising-edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port req  input  2  per-requester run request, level, held until its rsp_valid.
REQ-007 SHALL have port req_n  input  2*WIDTH  per-requester count N; requester i uses bits [i*WIDTH +: WIDTH].
REQ-008 SHALL have port gnt  output  2  one-hot grant, held from LOAD through DONE.
REQ-009 SHALL have port rsp_valid  output  2  one-cycle completion pulse to the granted requester.
REQ-010 SHALL have port rsp_data  output  32  counter value captured at completion; valid with rsp_valid.
REQ-011 SHALL have port rsp_err  output  1  timeout flag; valid with rsp_valid.
REQ-012 SHALL have port busy  output  1  high whenever the state is not IDLE.
REQ-013 SHALL have port cnt_N  output  WIDTH  target count to the shared counter.
REQ-014 SHALL have port cnt_en  output  1  count-enable pulse to the counter.
REQ-015 SHALL have port cnt_clr  output  1  one-cycle counter clear pulse.
REQ-016 SHALL have port cnt_out  input  32  counter current value.
REQ-017 SHALL have port cnt_done  input  1  counter reached N.

Function
REQ-018 SHALL implement an FSM with states IDLE, LOAD, RUN, DONE.
REQ-019 In IDLE with any req high, SHALL grant via round-robin (priority pointer starts at requester 0 and moves to the other requester after each grant), then enter LOAD.
REQ-020 In LOAD (exactly 1 cycle), SHALL assert cnt_clr, latch cnt_N from the granted requester's req_n, and assert gnt.
REQ-021 If the latched N is 0, SHALL go LOAD->DONE with rsp_data=0 and no cnt_en pulse; otherwise LOAD->RUN.
REQ-022 In RUN, SHALL assert cnt_en for one cycle when the prescale counter (cleared on RUN entry) equals PRESCALE-1, then wrap it to 0.
REQ-023 SHALL go RUN->DONE in the cycle after cnt_done is sampled high, capture cnt_out into rsp_data, and not assert cnt_en in any cycle where cnt_done is high.
REQ-024 In DONE (1 cycle), SHALL pulse rsp_valid for the granted requester only; gnt clears on the next cycle and state returns to IDLE.
REQ-025 If the granted requester drops req during LOAD or RUN, SHALL abort: pulse cnt_clr, produce no rsp_valid, and return to IDLE.
REQ-026 A req still high in IDLE after DONE SHALL be treated as a new request.
REQ-027 With both requests pending continuously, grants SHALL alternate 0,1,0,1.

Reset
REQ-028 On rst, SHALL enter IDLE asynchronously, zero every output (gnt, rsp_valid, rsp_data, rsp_err, busy, cnt_N, cnt_en, cnt_clr), and reset the pointer to requester 0.
REQ-029 If rst asserts mid-run, SHALL drop the run with no response.

Configuration
REQ-030 With COUNTER_SCHED_TIMEOUT_EN defined, SHALL count RUN cycles and, on reaching TIMEOUT without cnt_done, go to DONE with rsp_err=1 and rsp_data=cnt_out.
REQ-031 Without COUNTER_SCHED_TIMEOUT_EN, SHALL omit the timeout counter, and rsp_err SHALL be constant 0.

Structure
REQ-032 Package counter_sched_pkg SHALL hold the state enum, NREQ=2, and the default WIDTH and PRESCALE constants.
REQ-033 Round-robin selection SHALL live in sub-module rr_arb2 (inputs req and pointer; output one-hot grant).

Verification
REQ-034 req=01, N0=14, PRESCALE=2 -> gnt=01; 14 cnt_en pulses 2 cycles apart; rsp_valid=01 with rsp_data=14 and rsp_err=0.
REQ-035 req=11 held, N0=3, N1=5 -> grant order 0,1,0; responses carry 3, 5, 3.
REQ-036 req=10, N1=0 -> LOAD->DONE; rsp_valid=10 with rsp_data=0 and zero cnt_en pulses.
REQ-037 req0 dropped after 4 cnt_en pulses of an N=10 run -> cnt_clr pulse, no rsp_valid, busy=0 the next cycle.
REQ-038 rst asserted mid-RUN -> all outputs 0 immediately; the next grant goes to requester 0.
REQ-039 With COUNTER_SCHED_TIMEOUT_EN and TIMEOUT=16, cnt_done tied 0 -> rsp_valid with rsp_err=1 exactly 16 cycles after RUN entry.
